circuit_i_arbiter: RTL
======================

# circuit_i_arbiter

Two-requester arbiter and sequencer for the shared 16-bit, 4-operation combinational unit (operands A/B, 2-bit select S, 16-bit result). It accepts operation requests from two independent masters. It grants the unit to one of them, drives the operands and select from registers, and captures the unit's result one cycle later. It then returns the result to the winner with a done pulse. The block sits between the datapath masters and the single unit instance, so the unit is never driven by two sources at once.

## Interface
- WIDTH, 16, operand and result width
- SEL_W, 2, operation select width
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- REQ  input  2  per-requester request level; bit n = requester n
- A0, B0  input  WIDTH each  requester 0 operands
- S0  input  SEL_W  requester 0 operation select
- A1, B1  input  WIDTH each  requester 1 operands
- S1  input  SEL_W  requester 1 operation select
- GNT  output  2  one-hot, one-cycle grant pulse
- DONE  output  2  one-hot, one-cycle completion pulse
- RESULT  output  WIDTH  captured unit result; holds until the next capture
- BUSY  output  1  high while the state is EXEC
- OPS_DONE  output  8  count of completed operations; wraps 255 -> 0
- UNIT_A, UNIT_B  output  WIDTH each  registered operands to the shared unit
- UNIT_S  output  SEL_W  registered select to the shared unit
- UNIT_Y  input  WIDTH  unit result, combinational from UNIT_A, UNIT_B and UNIT_S

## Operation
- **States.** Two states, IDLE and EXEC. An internal OWNER bit records the granted requester. An internal PRI bit records the preferred requester.
- **IDLE with REQ == 0.** Stay in IDLE. All outputs hold, except GNT and DONE, which are 0.
- **IDLE with exactly one REQ bit set.**
  - Grant that requester.
  - Latch its A, B and S into UNIT_A, UNIT_B and UNIT_S.
  - Set OWNER to that requester, pulse GNT[OWNER], go to EXEC.
- **IDLE with REQ == 2'b11.**
  - The requester selected by PRI wins.
  - The loser keeps waiting; its request is not lost.
- **EXEC.**
  - REQ is ignored.
  - At the edge, capture UNIT_Y into RESULT, pulse DONE[OWNER] and increment OPS_DONE.
  - Set PRI to the requester that did not win (~OWNER), return to IDLE.
- **Requester rules.**
  - Hold REQ and the operands stable until GNT is seen.
  - Drop REQ in the cycle GNT is high. REQ still high on the return to IDLE is a new request.
  - Operands may change freely after GNT, because the unit inputs are registered.
- **Unit inputs.** UNIT_A, UNIT_B and UNIT_S change only on a grant edge. They are held through EXEC and afterwards.
- **Width.** RESULT is exactly WIDTH bits of UNIT_Y. No extension or truncation is done in this block.

## Timing
- **Reset values.** All outputs are 0, state is IDLE and PRI is 0. This covers GNT, DONE, RESULT, BUSY, OPS_DONE, UNIT_A, UNIT_B and UNIT_S.
- **Latency.** REQ is sampled at edge k. GNT is high in cycle k+1, along with BUSY=1 and valid unit inputs. RESULT and DONE are valid in cycle k+2.
- **Throughput.** One operation per 2 cycles. Under continuous contention the requesters strictly alternate.
- **GNT and DONE.** Never both high in the same cycle. Each has at most one bit set.
- **OPS_DONE wrap.** At 255, a completion sets the count to 0 with no other effect.
- **RESET high in EXEC.**
  - Abort the operation: no DONE, RESULT becomes 0, OPS_DONE is not incremented.
  - PRI becomes 0. The requester must re-request.
- **RESET has priority** over all other events in the same cycle.

## Configuration
- **CIRCUIT_I_ARB_RR_EN defined.** Round-robin arbitration via PRI, as described above.
- **CIRCUIT_I_ARB_RR_EN undefined.**
  - Fixed priority: requester 0 always wins a tie.
  - The PRI register is removed.
  - Requester 1 can starve under continuous REQ[0].
- Everything else is identical in both builds.

## Test plan
The bench models the unit as follows: S=0 gives A+B, S=1 gives A-B, S=2 gives A&B, S=3 gives A|B.
- **Reset.** Hold RESET for 2 cycles. All outputs read 0 and BUSY=0.
- **Single request, S=0.** REQ=01, A0=12, B0=13, S0=0.
  - GNT=01 in cycle k+1, with UNIT_A=12 and UNIT_B=13.
  - DONE=01 in cycle k+2, with RESULT=25 and OPS_DONE=1.
- **Contention.** REQ=11 held for 4 operations, with requester 1 on A1=12, B1=13, S1=3.
  - With RR: grants go 0,1,0,1.
  - Requester 1 sees RESULT=13 (12|13).
  - Without the macro: grants go 0,0,0,0.
- **Operand change after GNT.** Change A0 to 0 during the GNT cycle. RESULT still reflects the latched A0=12.
- **Reset mid-operation.** Assert RESET during EXEC.
  - No DONE.
  - RESULT=0, OPS_DONE unchanged from 0, state IDLE.
- **Counter wrap.** Run 256 operations. OPS_DONE goes 255 -> 0, and the next completion gives 1.

Source files
------------

// File: rtl/circuit_i_arbiter.sv
// rtl/circuit_i_arbiter.sv - two-requester arbiter/sequencer for a shared combinational unit
// Define CIRCUIT_I_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module circuit_i_arbiter #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [SEL_W-1:0] S0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [SEL_W-1:0] S1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic [7:0]       OPS_DONE,
  output logic [WIDTH-1:0] UNIT_A,
  output logic [WIDTH-1:0] UNIT_B,
  output logic [SEL_W-1:0] UNIT_S,
  input  logic [WIDTH-1:0] UNIT_Y
);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       ops_q, ops_d;
  logic [WIDTH-1:0] unit_a_q, unit_a_d;
  logic [WIDTH-1:0] unit_b_q, unit_b_d;
  logic [SEL_W-1:0] unit_s_q, unit_s_d;
  logic             win;

`ifdef CIRCUIT_I_ARB_RR_EN
  logic pri_q, pri_d;
  // On a tie the preferred requester wins; a lone request wins outright.
  assign win = (REQ == 2'b11) ? pri_q : ~REQ[0];
`else
  assign win = ~REQ[0];
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    result_d = result_q;
    ops_d    = ops_q;
    unit_a_d = unit_a_q;
    unit_b_d = unit_b_q;
    unit_s_d = unit_s_q;
`ifdef CIRCUIT_I_ARB_RR_EN
    pri_d    = pri_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          owner_d  = win;
          gnt_d    = win ? 2'b10 : 2'b01;
          unit_a_d = win ? A1 : A0;
          unit_b_d = win ? B1 : B0;
          unit_s_d = win ? S1 : S0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        result_d = UNIT_Y;
        done_d   = owner_q ? 2'b10 : 2'b01;
        ops_d    = ops_q + 8'd1;
`ifdef CIRCUIT_I_ARB_RR_EN
        pri_d    = ~owner_q;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset also aborts an operation in flight: no DONE, RESULT cleared.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= '0;
      ops_q    <= 8'd0;
      unit_a_q <= '0;
      unit_b_q <= '0;
      unit_s_q <= '0;
`ifdef CIRCUIT_I_ARB_RR_EN
      pri_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      ops_q    <= ops_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
      unit_s_q <= unit_s_d;
`ifdef CIRCUIT_I_ARB_RR_EN
      pri_q    <= pri_d;
`endif
    end
  end

  assign GNT      = gnt_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign BUSY     = (state_q == EXEC);
  assign OPS_DONE = ops_q;
  assign UNIT_A   = unit_a_q;
  assign UNIT_B   = unit_b_q;
  assign UNIT_S   = unit_s_q;

endmodule
